issue_skid_buffer: RTL
======================

// Module: issue_skid_buffer
// PURPOSE
//  Two-lane elastic buffer between producer_fsm and pipeline_wrapped.
//  - Absorbs producer traffic while the pipeline asserts stall_1/stall_2.
//  - Applies per-lane flush so stale words never reach the pipeline.
//  - Gives the producer a ready/valid handshake in place of free-running issue.
// PARAMETERS
//  DATA_W        32  width of each lane's data word
//  DEPTH         4   entries per lane FIFO; power of 2, >=2
//  GLOBAL_STALL  1   1: either stall holds both lanes; 0: stall_i holds lane i only
// PORTS
//  clk           in   1       single clock, rising edge
//  reset         in   1       asynchronous, active-high
//  prod_data_1   in   DATA_W  lane 1 word from producer
//  prod_data_2   in   DATA_W  lane 2 word from producer
//  prod_valid    in   2       bit i-1 = lane i word offered
//  prod_ready    out  2       bit i-1 = lane i can accept
//  flush_1       in   1       discard all lane 1 contents
//  flush_2       in   1       discard all lane 2 contents
//  stall_1       in   1       pipeline lane 1 cannot accept
//  stall_2       in   1       pipeline lane 2 cannot accept
//  pipe_data_1   out  DATA_W  lane 1 head word to pipeline
//  pipe_data_2   out  DATA_W  lane 2 head word to pipeline
//  pipe_valid    out  2       bit i-1 = lane i head word valid this cycle
//  occupancy_1   out  $clog2(DEPTH)+1  lane 1 entry count
//  occupancy_2   out  $clog2(DEPTH)+1  lane 2 entry count
// BEHAVIOUR
//  Reset
//  - Pointers and counts go to 0; prod_ready=2'b00 while reset is high, 2'b11 on the first cycle after.
//  - pipe_valid=0; pipe_data=0; lane state EMPTY.
//  Pointers
//  - Per-lane FIFO uses rd/wr pointers with an extra wrap bit.
//  - full = (ptrs differ only in MSB); empty = (ptrs equal).
//  Push and pop
//  - Push on clk when prod_valid[i] & prod_ready[i].
//  - prod_ready[i] = !full_i & !flush_i. It is conservative: when full, no push even if a pop occurs the same cycle.
//  - hold_i = GLOBAL_STALL ? (stall_1|stall_2) : stall_i.
//  - pipe_valid[i] = !empty_i & !hold_i & !flush_i (combinational).
//  - pipe_data_i = mem[rd_ptr] (combinational).
//  - Pop on clk when pipe_valid[i]. The pipeline consumes the word in that same cycle.
//  - Latency: a word pushed at edge N is presentable from cycle N+1. There is no bypass of an empty FIFO.
//  - Simultaneous push and pop on a non-full lane: occupancy is unchanged; both pointers advance.
//  Flush
//  - flush_i clears lane i at the next edge: rd_ptr<=wr_ptr, occupancy<=0.
//  - A same-cycle push is dropped, because prod_ready is already low.
//  - The other lane is unaffected.
//  Lane FSM (per lane)
//  - EMPTY  -> FILL on push.
//  - FILL   -> BLOCK when hold & !empty.
//  - FILL   -> EMPTY when the last entry pops with no push.
//  - BLOCK  -> FILL when hold is released.
//  - any    -> EMPTY on flush or reset.
//  - FULL is a flag, not a state.
//  Other rules
//  - Reset asserted mid-transfer discards all contents immediately (asynchronous).
//  - Data is never modified; occupancy never exceeds DEPTH.
// CONFIGURATION
//  ISSUE_BUF_STATS_EN defined
//  - Adds outputs stall_cycles_1/2 and flushed_words_1/2, each 32 bits, reset to 0.
//  - stall_cycles_i increments each cycle in BLOCK.
//  - flushed_words_i adds the occupancy at each flush_i.
//  - Counters saturate at 2^32-1.
//  ISSUE_BUF_STATS_EN undefined
//  - Ports and logic are absent; all other behaviour is identical.
// STRUCTURE
//  issue_buf_pkg
//  - LANES=2.
//  - lane_state_e {EMPTY,FILL,BLOCK}.
//  - Default DEPTH/DATA_W.
//  - Pointer-width helper.
//  Sub-module issue_lane_fifo
//  - Instanced once per lane: storage, pointers, FSM, optional stats.
//  Top level
//  - Only forms hold_i per GLOBAL_STALL and maps the ports.
// TESTING
//  - Reset, then push 0xA1 on lane 1 with no stall
//    -> pipe_valid=01 and pipe_data_1=0xA1 one cycle later; occupancy_1 back to 0.
//  - stall_1=1 with GLOBAL_STALL=1, push 4 words per lane
//    -> prod_ready=00 after the 4th; pipe_valid=00.
//    Release stall -> words emerge in order, one per cycle.
//  - Lane 1 holds 3 words; assert flush_1 with prod_valid=01
//    -> occupancy_1=0 next cycle, no lane-1 output, lane 2 unaffected.
//  - GLOBAL_STALL=0, stall_2=1 only -> lane 1 streams; lane 2 fills to DEPTH.
//  - Push and pop every cycle for 20 cycles -> occupancy constant; pointers wrap twice with no loss.
//  - Assert reset while both lanes are full -> occupancy=0 and pipe_valid=00 at once, with no clock needed.

Source files
------------

// File: rtl/issue_skid_buffer_pkg.sv
// Shared types and constants for the two-lane issue skid buffer.
// The optional statistics counters are enabled with ISSUE_BUF_STATS_EN.
package issue_buf_pkg;

  localparam int LANES      = 2;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    BLOCK = 2'd2
  } lane_state_e;

  // Pointer width: index bits plus one wrap bit to tell full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/issue_skid_buffer_if.sv
// Producer/pipeline handshake bundle for issue_skid_buffer.
// Statistics outputs exist only when ISSUE_BUF_STATS_EN is defined.
interface issue_skid_buffer_if
  import issue_buf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);

  localparam int PW = ptr_w(DEPTH);

  // Producer side
  logic [DATA_W-1:0] prod_data_1;
  logic [DATA_W-1:0] prod_data_2;
  logic [LANES-1:0]  prod_valid;
  logic [LANES-1:0]  prod_ready;

  // Pipeline control
  logic              flush_1;
  logic              flush_2;
  logic              stall_1;
  logic              stall_2;

  // Pipeline side
  logic [DATA_W-1:0] pipe_data_1;
  logic [DATA_W-1:0] pipe_data_2;
  logic [LANES-1:0]  pipe_valid;
  logic [PW-1:0]     occupancy_1;
  logic [PW-1:0]     occupancy_2;

`ifdef ISSUE_BUF_STATS_EN
  logic [31:0]       stall_cycles_1;
  logic [31:0]       stall_cycles_2;
  logic [31:0]       flushed_words_1;
  logic [31:0]       flushed_words_2;
`endif

  // Environment side: drives producer data and pipeline control.
  modport master (
    output prod_data_1, prod_data_2, prod_valid, flush_1, flush_2, stall_1, stall_2,
`ifdef ISSUE_BUF_STATS_EN
    input  stall_cycles_1, stall_cycles_2, flushed_words_1, flushed_words_2,
`endif
    input  prod_ready, pipe_data_1, pipe_data_2, pipe_valid, occupancy_1, occupancy_2
  );

  // Buffer side.
  modport slave (
    input  prod_data_1, prod_data_2, prod_valid, flush_1, flush_2, stall_1, stall_2,
`ifdef ISSUE_BUF_STATS_EN
    output stall_cycles_1, stall_cycles_2, flushed_words_1, flushed_words_2,
`endif
    output prod_ready, pipe_data_1, pipe_data_2, pipe_valid, occupancy_1, occupancy_2
  );

endinterface

// File: rtl/issue_skid_buffer_lane_fifo.sv
// One lane of the issue skid buffer: storage, wrap-bit pointers, lane FSM
// and, when ISSUE_BUF_STATS_EN is defined, saturating stall/flush counters.
// Read is combinational so a stored word is presentable the cycle after push.
module issue_lane_fifo
  import issue_buf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH   // power of 2, >= 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_flush,
  input  logic                     i_hold,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_valid,
  output logic [ptr_w(DEPTH)-1:0]  o_occupancy
`ifdef ISSUE_BUF_STATS_EN
  ,
  output logic [31:0]              o_stall_cycles,
  output logic [31:0]              o_flushed_words
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  lane_state_e       r_state;
  lane_state_e       w_state_next;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [PW-1:0]     w_occ;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_occ   = r_wr_ptr - r_rd_ptr;

  // Ready ignores a same-cycle pop when full; low while reset or flushing.
  assign o_ready = !reset && !w_full && !i_flush;
  assign w_push  = i_valid && o_ready;

  // The pipeline takes the head word in the same cycle it is valid.
  assign o_valid = !w_empty && !i_hold && !i_flush;
  assign w_pop   = o_valid;

  // Empty lane shows zero so stale storage never appears on the bus.
  assign o_data      = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_occupancy = w_occ;

  // Storage write; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  // Pointer update: flush drops everything by snapping rd onto wr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (i_flush) begin
        r_rd_ptr <= r_wr_ptr;
      end else if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Lane state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Lane next-state: flush wins, otherwise follow push/hold/last-pop events.
  always_comb begin
    w_state_next = r_state;
    if (i_flush) begin
      w_state_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) w_state_next = FILL;
        end
        FILL: begin
          if (i_hold && !w_empty) begin
            w_state_next = BLOCK;
          end else if (w_pop && !w_push && (w_occ == PW'(1))) begin
            w_state_next = EMPTY;
          end
        end
        BLOCK: begin
          if (!i_hold) w_state_next = FILL;
        end
        default: w_state_next = EMPTY;
      endcase
    end
  end

`ifdef ISSUE_BUF_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flushed_words;
  logic [32:0] w_flush_sum;

  assign w_flush_sum = {1'b0, r_flushed_words} + 33'(w_occ);

  // Saturating counters: cycles spent blocked, words discarded by flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles  <= '0;
      r_flushed_words <= '0;
    end else begin
      if ((r_state == BLOCK) && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (i_flush) begin
        r_flushed_words <= w_flush_sum[32] ? '1 : w_flush_sum[31:0];
      end
    end
  end

  assign o_stall_cycles  = r_stall_cycles;
  assign o_flushed_words = r_flushed_words;
`endif

endmodule

// File: rtl/issue_skid_buffer.sv
// Two-lane elastic buffer between the producer FSM and the wrapped pipeline.
// Forms each lane's hold from the stalls and maps the bundle onto two lanes.
// ISSUE_BUF_STATS_EN adds per-lane stall/flush statistics outputs.
module issue_skid_buffer
  import issue_buf_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DEPTH        = DEF_DEPTH,   // power of 2, >= 2
  parameter int GLOBAL_STALL = 1            // 1: any stall holds both lanes
) (
  input  logic               clk,
  input  logic               reset,
  issue_skid_buffer_if.slave bus
);

  localparam int PW = ptr_w(DEPTH);

  logic [DATA_W-1:0] w_prod_data [LANES];
  logic [DATA_W-1:0] w_pipe_data [LANES];
  logic [PW-1:0]     w_occ       [LANES];
  logic [LANES-1:0]  w_flush;
  logic [LANES-1:0]  w_stall;
  logic [LANES-1:0]  w_hold;
  logic [LANES-1:0]  w_ready;
  logic [LANES-1:0]  w_valid;

  assign w_prod_data[0] = bus.prod_data_1;
  assign w_prod_data[1] = bus.prod_data_2;
  assign w_flush        = {bus.flush_2, bus.flush_1};
  assign w_stall        = {bus.stall_2, bus.stall_1};

`ifdef ISSUE_BUF_STATS_EN
  logic [31:0] w_stall_cycles  [LANES];
  logic [31:0] w_flushed_words [LANES];
`endif

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_hold[gi] = (GLOBAL_STALL != 0) ? (|w_stall) : w_stall[gi];

      issue_lane_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
      ) u_lane (
        .clk             (clk),
        .reset           (reset),
        .i_data          (w_prod_data[gi]),
        .i_valid         (bus.prod_valid[gi]),
        .o_ready         (w_ready[gi]),
        .i_flush         (w_flush[gi]),
        .i_hold          (w_hold[gi]),
        .o_data          (w_pipe_data[gi]),
        .o_valid         (w_valid[gi]),
        .o_occupancy     (w_occ[gi])
`ifdef ISSUE_BUF_STATS_EN
        ,
        .o_stall_cycles  (w_stall_cycles[gi]),
        .o_flushed_words (w_flushed_words[gi])
`endif
      );
    end
  endgenerate

  assign bus.prod_ready  = w_ready;
  assign bus.pipe_valid  = w_valid;
  assign bus.pipe_data_1 = w_pipe_data[0];
  assign bus.pipe_data_2 = w_pipe_data[1];
  assign bus.occupancy_1 = w_occ[0];
  assign bus.occupancy_2 = w_occ[1];

`ifdef ISSUE_BUF_STATS_EN
  assign bus.stall_cycles_1  = w_stall_cycles[0];
  assign bus.stall_cycles_2  = w_stall_cycles[1];
  assign bus.flushed_words_1 = w_flushed_words[0];
  assign bus.flushed_words_2 = w_flushed_words[1];
`endif

endmodule
